i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 14 +
 rtl/i2s_tx_if.sv | 24 ++
 rtl/i2s_bck_gen.sv | 41 ++++
 rtl/i2s_tx.sv | 99 +++++++++
 tb/tb_i2s_tx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared widths and the sample-format helper for the I2S transmitter.
package audio_pkg;

  localparam int SLOT_W     = 16;
  localparam int FRAME_BITS = 32;
  localparam int IN_W       = 15;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // Offset-binary mixer sum to signed 16-bit, LSB zero-padded.
  function automatic logic [SLOT_W-1:0] to_signed16(input logic [IN_W-1:0] x);
    return {x, 1'b0} ^ 16'h8000;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Mixer-to-serializer bundle: sample inputs plus the I2S pins and frame strobe.
interface i2s_tx_if;
  import audio_pkg::*;

  logic [IN_W-1:0] left;
  logic [IN_W-1:0] right;
  logic            mute;
  logic            i2s_bck;
  logic            i2s_lrck;
  logic            i2s_data;
  logic            strobe;

  // Upstream side: supplies samples, watches the strobe and the serial pins.
  modport master (
    output left, right, mute,
    input  i2s_bck, i2s_lrck, i2s_data, strobe
  );

  // Serializer side.
  modport slave (
    input  left, right, mute,
    output i2s_bck, i2s_lrck, i2s_data, strobe
  );
endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: prescaler divides the system clock by 2*BCK_DIV and
// flags the cycle on which BCK falls so the slot logic can advance.
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic i2s_bck,
  output logic fall_tick
);

  localparam logic [7:0] DIV_MAX = 8'(BCK_DIV - 1);

  logic [7:0] presc_q, presc_d;
  logic       bck_q, bck_d;
  logic       wrap;

  // Prescaler wrap, BCK toggle and falling-edge detect.
  always_comb begin
    // NOTE: every signal written here gets a value on all paths, so no latch is inferred.
    wrap      = (presc_q == DIV_MAX);
    presc_d   = wrap ? 8'd0 : presc_q + 8'd1;
    bck_d     = wrap ? ~bck_q : bck_q;
    fall_tick = wrap && bck_q;
  end

  // Prescaler and BCK registers.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (reset) begin
      presc_q <= 8'd0;
      bck_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bck_q   <= bck_d;
    end
  end

  assign i2s_bck = bck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: latches one stereo pair per 32-bit frame and shifts it out
// MSB-first. Define I2S_LJ_EN for left-justified output (no one-BCK delay).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input logic    clock,
  input logic    reset,
  i2s_tx_if.slave bus
);

  logic fall_tick;
  logic bck;

  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clock     (clock),
    .reset     (reset),
    .i2s_bck   (bck),
    .fall_tick (fall_tick)
  );

  logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
  logic                    lrck_q, lrck_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    data_q, data_d;
  logic                    strobe_q, strobe_d;
`ifndef I2S_LJ_EN
  logic                    delay_q, delay_d;
`endif

  logic                    latch;
  logic [FRAME_BITS-1:0]   word;
  logic                    serial_bit;

  // Slot sequencing: count bits, latch a new pair at the frame wrap, shift on every fall.
  always_comb begin
    bitcnt_d   = bitcnt_q;
    lrck_d     = lrck_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
`ifndef I2S_LJ_EN
    delay_d    = delay_q;
`endif
    latch      = fall_tick && (&bitcnt_q);
    strobe_d   = latch;
    word       = bus.mute ? '0 : {to_signed16(bus.left), to_signed16(bus.right)};
    serial_bit = 1'b0;

    if (fall_tick) begin
      bitcnt_d = bitcnt_q + 1'b1;
      lrck_d   = bitcnt_d[CNT_W-1];
      // The bit leaving now is the MSB of whichever word is current this tick.
      if (latch) begin
        serial_bit = word[FRAME_BITS-1];
        shreg_d    = {word[FRAME_BITS-2:0], 1'b0};
      end else begin
        serial_bit = shreg_q[FRAME_BITS-1];
        shreg_d    = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
`ifdef I2S_LJ_EN
      data_d  = serial_bit;
`else
      // Standard I2S: the pin lags the slot stream by one BCK.
      data_d  = delay_q;
      delay_d = serial_bit;
`endif
    end
  end

  // Slot state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt_q <= '1;
      lrck_q   <= 1'b1;
      shreg_q  <= '0;
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
`ifndef I2S_LJ_EN
      delay_q  <= 1'b0;
`endif
    end else begin
      bitcnt_q <= bitcnt_d;
      lrck_q   <= lrck_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
`ifndef I2S_LJ_EN
      delay_q  <= delay_d;
`endif
    end
  end

  assign bus.i2s_bck  = bck;
  assign bus.i2s_lrck = lrck_q;
  assign bus.i2s_data = data_q;
  assign bus.strobe   = strobe_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx. Expected pin values come from a time-based
// model: clock count since reset gives BCK phase, tick index and slot bit.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int D   = 2;
  localparam int TPF = 2 * D;

  logic clock = 1'b0;
  logic reset = 1'b1;

  i2s_tx_if bus ();

  i2s_tx #(.BCK_DIV(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          t;
  int          k;
  bit          is_tick;
  bit          latch_m;
  logic [15:0] cur_l, cur_r;
  logic        prev_r0;
  logic        m_data;
  logic        m_lrck;
  int          last_st;

  // Receiver state (built from DUT pins)
  logic [15:0] rx_l, rx_r, got_l, got_r;
  bit          rx_done;

  function automatic logic [15:0] ref_word(input logic [14:0] x, input logic m);
    int v;
    if (m) return 16'h0000;
    v = (int'(x) - 16384) * 2;
    return 16'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic d;
    @(posedge clock);
    if (reset) begin
      t = 0; k = 31; is_tick = 0; latch_m = 0;
      cur_l = 16'h0; cur_r = 16'h0; prev_r0 = 1'b0;
      m_data = 1'b0; m_lrck = 1'b1; last_st = -1;
    end else begin
      t++;
      is_tick = (t % TPF) == 0;
      latch_m = 0;
      if (is_tick) begin
        k = ((t / TPF) - 1) % 32;
        m_lrck = (k >= 16);
        if (k == 0) begin
          latch_m = 1;
          prev_r0 = cur_r[0];
          cur_l   = ref_word(bus.left, bus.mute);
          cur_r   = ref_word(bus.right, bus.mute);
        end
`ifdef I2S_LJ_EN
        m_data = (k < 16) ? cur_l[15-k] : cur_r[31-k];
`else
        if (k == 0)       m_data = prev_r0;
        else if (k <= 16) m_data = cur_l[16-k];
        else              m_data = cur_r[32-k];
`endif
      end
    end
    @(negedge clock);
    check("bck",    32'(bus.i2s_bck),  32'((t / D) % 2));
    check("lrck",   32'(bus.i2s_lrck), 32'(m_lrck));
    check("data",   32'(bus.i2s_data), 32'(m_data));
    check("strobe", 32'(bus.strobe),   32'(latch_m));
    if (bus.strobe === 1'b1) begin
      if (last_st < 0) check("first_strobe", 32'(t), 32'(TPF));
      else             check("strobe_gap", 32'(t - last_st), 32'(TPF * 32));
      last_st = t;
    end
    if (is_tick) begin
      d = bus.i2s_data;
`ifdef I2S_LJ_EN
      if (k < 16) rx_l[15-k] = d; else rx_r[31-k] = d;
      if (k == 31) begin got_l = rx_l; got_r = rx_r; rx_done = 1; end
`else
      if (k == 0) begin rx_r[0] = d; got_l = rx_l; got_r = rx_r; rx_done = 1; end
      else if (k <= 16) rx_l[16-k] = d;
      else rx_r[32-k] = d;
`endif
    end
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.strobe !== 1'b1 && n < 400);
    if (bus.strobe !== 1'b1) begin
      vectors++;
      miscompares++;
      $error("FAIL latch_timeout: observed no strobe expected strobe within 400 clocks");
    end
  endtask

  task automatic recv_frame();
    int n;
    n = 0;
    rx_done = 0;
    do begin
      tick();
      n++;
    end while (!rx_done && n < 400);
    if (!rx_done) begin
      vectors++;
      miscompares++;
      $error("FAIL frame_timeout: observed no complete frame expected one within 400 clocks");
    end
  endtask

  task automatic send_frame(input string tag, input logic [14:0] l, input logic [14:0] r,
                            input logic m, input logic [15:0] el, input logic [15:0] er);
    int n;
    bus.left = l; bus.right = r; bus.mute = m;
    wait_latch(n);
    recv_frame();
    check({tag, "_left"},  32'(got_l), 32'(el));
    check({tag, "_right"}, 32'(got_r), 32'(er));
  endtask

  initial begin
    int n;
    logic [15:0] exp_l;
    logic [14:0] rl, rr;
    logic        rm;

    bus.left = '0; bus.right = '0; bus.mute = 1'b0;
    rx_l = '0; rx_r = '0; got_l = '0; got_r = '0; rx_done = 0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_bck",    32'(bus.i2s_bck),  32'd0);
    check("rst_lrck",   32'(bus.i2s_lrck), 32'd1);
    check("rst_data",   32'(bus.i2s_data), 32'd0);
    check("rst_strobe", 32'(bus.strobe),   32'd0);
    reset = 1'b0;

    // First latch 2*BCK_DIV clocks after reset release; zero inputs give 8000/8000.
    wait_latch(n);
    check("first_latch_clocks", 32'(n), 32'(TPF));
    recv_frame();
    check("frame0_left",  32'(got_l), 32'h8000);
    check("frame0_right", 32'(got_r), 32'h8000);

    send_frame("mid_full", 15'h4000, 15'h7FFF, 1'b0, 16'h0000, 16'h7FFE);
    send_frame("zero_one", 15'h0000, 15'h0001, 1'b0, 16'h8000, 16'h8002);

    // Left changes every clock; only the value at the latch edge is sent.
    n = 0;
    do begin
      bus.left = 15'($urandom);
      tick();
      n++;
    end while (bus.strobe !== 1'b1 && n < 400);
    exp_l = ref_word(bus.left, 1'b0);
    rx_done = 0;
    n = 0;
    do begin
      bus.left = 15'($urandom);
      tick();
      n++;
    end while (!rx_done && n < 400);
    check("churn_left", 32'(got_l), 32'(exp_l));

    // Mute at the latch point clears both slots.
    send_frame("mute_latch", 15'h7FFF, 15'h7FFF, 1'b1, 16'h0000, 16'h0000);

    // Mute pulsed mid-frame only: no effect.
    bus.mute = 1'b0;
    wait_latch(n);
    recv_frame();
    wait_latch(n);
    for (int i = 0; i < 50; i++) begin
      bus.mute = (i >= 10);
      tick();
    end
    bus.mute = 1'b0;
    recv_frame();
    check("mute_mid_left",  32'(got_l), 32'h7FFE);
    check("mute_mid_right", 32'(got_r), 32'h7FFE);

    // Random frames.
    for (int i = 0; i < 3; i++) begin
      rl = 15'($urandom);
      rr = 15'($urandom);
      rm = ($urandom_range(3) == 0);
      send_frame("rand", rl, rr, rm, ref_word(rl, rm), ref_word(rr, rm));
    end

    // Reset for one clock at bitcnt=10; frame restarts cleanly.
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_tick && k == 10) && n < 400);
    reset = 1'b1;
    tick();
    check("midrst_bck",    32'(bus.i2s_bck),  32'd0);
    check("midrst_lrck",   32'(bus.i2s_lrck), 32'd1);
    check("midrst_data",   32'(bus.i2s_data), 32'd0);
    check("midrst_strobe", 32'(bus.strobe),   32'd0);
    reset = 1'b0;
    bus.left = 15'h1234; bus.right = 15'h0ABC;
    wait_latch(n);
    check("restart_clocks", 32'(n), 32'(TPF));
    recv_frame();
    check("restart_left",  32'(got_l), 32'(ref_word(15'h1234, 1'b0)));
    check("restart_right", 32'(got_r), 32'(ref_word(15'h0ABC, 1'b0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
